// File: rtl/hex_scan_pkg.sv
// Shared definitions for the multiplexed hex display scanner:
// scan FSM state encoding and active-low seven-segment codes.
// Segment bit order: bit0=a, bit1=b, ... bit6=g; a 0 lights the segment.
package hex_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_seg_decoder
  import hex_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/hex_scan_ctrl.sv
// Multiplexed hex display scan controller.
// Each digit is preceded by one dark BLANK cycle (anti-ghosting) and then
// driven for PRESCALE cycles. New values are staged in a pending register
// and only reach the display at a frame boundary (or at once while idle),
// so a frame is never shown half old, half new.
// Optional build macro: LEADING_ZERO_BLANK_EN -- darkens leading zero digits.
module hex_scan_ctrl
  import hex_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  wr_valid,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  wr_ready,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  state_e                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [DIGITS-1:0]     dp_q, dp_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  fdone_q, fdone_d;
  logic                  boundary;
  logic                  xfer;

  logic [3:0]            nibble;
  logic                  dp_sel;
  logic [DIGITS-1:0]     an_sel;
  logic [6:0]            dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  lzb;
`endif

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      dp_q       <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      dp_q       <= dp_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      fdone_q    <= fdone_d;
    end
  end

  // Scan FSM: prescaler, digit index, frame boundary detection
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    fdone_d  = 1'b0;
    boundary = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        idx_d   = '0;
        if (enable) state_d = ST_BLANK;
      end
      ST_BLANK: state_d = ST_DRIVE;
      ST_DRIVE: begin
        if (presc_q == PRESC_LAST) begin
          presc_d  = '0;
          idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_d  = ST_BLANK;
          boundary = (idx_q == IDX_LAST);
          fdone_d  = (idx_q == IDX_LAST);
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disable wins over everything; the pending/display contents survive
    if (!enable) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      idx_d    = '0;
      fdone_d  = 1'b0;
      boundary = 1'b0;
    end
  end

  // Write staging: transfer at boundary (or while idle) before accepting
  always_comb begin
    disp_d     = disp_q;
    dp_d       = dp_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    xfer       = pend_vld_q && (boundary || (state_q == ST_IDLE));
    if (xfer) begin
      disp_d     = pend_q;
      dp_d       = pend_dp_q;
      pend_vld_d = 1'b0;
    end
    // A write can only be accepted when nothing is pending, so it never
    // collides with a transfer of the same cycle
    if (wr_valid && wr_ready) begin
      pend_d     = wr_data;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  assign wr_ready   = ~pend_vld_q;
  assign frame_done = fdone_q;

  // Select the current digit's nibble, decimal point and anode
  always_comb begin
    nibble = 4'h0;
    dp_sel = 1'b0;
    an_sel = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lzb    = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nibble    = disp_q[4*i +: 4];
        dp_sel    = dp_q[i];
        an_sel[i] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if ((i > 0) && ((disp_q >> (4*i)) == '0)) lzb = 1'b1;
`endif
      end
    end
  end

  hex_seg_decoder u_dec (
    .nibble_i (nibble),
    .seg_n_o  (dec_seg)
  );

  // Output drive: dark outside DRIVE, otherwise the selected digit
  always_comb begin
    an_n  = '1;
    seg_n = SEG_BLANK;
    dp_n  = 1'b1;
    if (state_q == ST_DRIVE) begin
      an_n  = ~an_sel;
      seg_n = dec_seg;
      dp_n  = ~dp_sel;
`ifdef LEADING_ZERO_BLANK_EN
      if (lzb) seg_n = SEG_BLANK;
`endif
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Testbench for hex_scan_ctrl with DIGITS=4, PRESCALE=4.
// A timeline model (cycles since scanning started) predicts all outputs;
// directed literal checks pin the model at key points.
module tb_hex_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic [3:0]  dp_in;
  logic        wr_ready;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_on = 0;

  hex_scan_ctrl #(.DIGITS(4), .PRESCALE(4)) dut (
    .clock      (clk),
    .reset      (rst),
    .enable     (en),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .dp_in      (dp_in),
    .wr_ready   (wr_ready),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Model: run = -1 while idle, else cycles since the first BLANK (0).
  // Frame = 20 cycles: position p, slot p/5 is the digit, p%5==0 is blank.
  int          run;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pv, m_rdy, m_bnd, m_idle_x;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run = -1; m_disp = '0; m_dp = '0; m_pend = '0; m_pdp = '0; m_pv = 1'b0;
    end else begin
      m_rdy    = !m_pv;
      m_bnd    = en && (run >= 0) && ((run % 20) == 19);
      m_idle_x = (run < 0) && m_pv;
      if (m_bnd || m_idle_x) begin
        m_disp = m_pend; m_dp = m_pdp; m_pv = 1'b0;
      end
      if (wr_valid && m_rdy) begin
        m_pend = wr_data; m_pdp = dp_in; m_pv = 1'b1;
      end
      if (!en) run = -1;
      else     run = run + 1;
    end
  end

  // Compare process: every cycle, just after the active edge
  int         slot;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_fd;
  always @(posedge clk) begin
    #1;
    if (chk_on && !rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      e_fd = (run > 0) && ((run % 20) == 0);
      if (run >= 0 && (run % 5) != 0) begin
        slot  = (run % 20) / 5;
        e_an  = ~(4'b0001 << slot);
        e_seg = hexseg(m_disp[4*slot +: 4]);
        e_dp  = ~m_dp[slot];
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_disp >> (4*slot)) == 16'h0) e_seg = 7'h7F;
`endif
      end
      chk("model_an_n", 32'(an_n), 32'(e_an));
      chk("model_seg_n", 32'(seg_n), 32'(e_seg));
      chk("model_dp_n", 32'(dp_n), 32'(e_dp));
      chk("model_frame_done", 32'(frame_done), 32'(e_fd));
      chk("model_wr_ready", 32'(wr_ready), 32'(!m_pv));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until frame_done is seen (bounded); returns cycle of the pulse
  task automatic wait_fd(output int at);
    bit seen = 0;
    at = -1;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick(1);
      if (frame_done) begin
        seen = 1;
        at = cyc;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame_done: got no pulse expected one within 60 cycles");
    end
  endtask

  int t1, t2;
  bit got;

  initial begin
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; dp_in = '0;
    tick(2);
    chk("reset_an_n", 32'(an_n), 32'h0000000F);
    chk("reset_seg_n", 32'(seg_n), 32'h0000007F);
    chk("reset_dp_n", 32'(dp_n), 32'h1);
    chk("reset_wr_ready", 32'(wr_ready), 32'h1);
    chk("reset_frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;
    chk_on = 1;
    tick(1);

    // Free-running scan with zero display
    en = 1'b1;
    tick(1);
    chk("first_blank_an", 32'(an_n), 32'hF);
    tick(1);
    chk("digit0_an", 32'(an_n), 32'hE);
    chk("digit0_seg_zero", 32'(seg_n), 32'h40);
    wait_fd(t1);
    wait_fd(t2);
    chk("frame_period", 32'(t2 - t1), 32'd20);

    // Write in DRIVE: display unchanged until the boundary
    tick(2);
    wr_valid = 1'b1; wr_data = 16'h1234; dp_in = 4'b0001;
    tick(1);
    wr_valid = 1'b0;
    chk("write_ready_low", 32'(wr_ready), 32'h0);
    chk("old_value_kept", 32'(seg_n), 32'h40);
    wait_fd(t1);
    chk("ready_after_xfer", 32'(wr_ready), 32'h1);
    tick(1);
    chk("new_digit0_an", 32'(an_n), 32'hE);
    chk("new_digit0_seg", 32'(seg_n), 32'h19);
    chk("new_digit0_dp", 32'(dp_n), 32'h0);

    // Back-to-back writes, second held until accepted
    wr_valid = 1'b1; wr_data = 16'hABCD; dp_in = 4'b0000;
    tick(1);
    wr_data = 16'h8F07;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      if (wr_ready) got = 1;
      else tick(1);
    end
    chk("second_write_slot", 32'(got), 32'h1);
    tick(1);
    wr_valid = 1'b0;
    chk("first_value_shown", 32'(seg_n), 32'h21);
    chk("second_pending", 32'(wr_ready), 32'h0);
    wait_fd(t1);
    tick(1);
    chk("second_value_shown", 32'(seg_n), 32'h78);

    // Enable dropped mid-frame, then re-enabled
    tick(3);
    en = 1'b0;
    tick(1);
    chk("disable_an", 32'(an_n), 32'hF);
    chk("disable_seg", 32'(seg_n), 32'h7F);
    chk("disable_dp", 32'(dp_n), 32'h1);
    tick(2);
    en = 1'b1;
    tick(1);
    chk("reenable_blank", 32'(an_n), 32'hF);
    tick(1);
    chk("reenable_digit0", 32'(an_n), 32'hE);
    chk("reenable_seg", 32'(seg_n), 32'h78);

    // Write while idle: transfers on the following cycle
    en = 1'b0;
    tick(1);
    wr_valid = 1'b1; wr_data = 16'h0070; dp_in = 4'b0000;
    tick(1);
    wr_valid = 1'b0;
    chk("idle_write_pending", 32'(wr_ready), 32'h0);
    tick(1);
    chk("idle_xfer_ready", 32'(wr_ready), 32'h1);
    en = 1'b1;
    tick(2);
    chk("lz_digit0", 32'(seg_n), 32'h40);
    tick(5);
    chk("lz_digit1_an", 32'(an_n), 32'hD);
    chk("lz_digit1", 32'(seg_n), 32'h78);
    tick(5);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_digit2", 32'(seg_n), 32'h7F);
`else
    chk("lz_digit2", 32'(seg_n), 32'h40);
`endif
    tick(5);
    chk("lz_digit3_an", 32'(an_n), 32'h7);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_digit3", 32'(seg_n), 32'h7F);
`else
    chk("lz_digit3", 32'(seg_n), 32'h40);
`endif

    // Asynchronous reset in the middle of DRIVE
    tick(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", 32'(an_n), 32'hF);
    chk("async_rst_seg", 32'(seg_n), 32'h7F);
    chk("async_rst_dp", 32'(dp_n), 32'h1);
    chk("async_rst_ready", 32'(wr_ready), 32'h1);
    chk("async_rst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);
    chk("after_rst_digit0_seg", 32'(seg_n), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of multiplexed digits (legal range 2..8).
REQ-002 SHALL have parameter PRESCALE, default 50000, meaning clock cycles each digit is driven per scan slot (legal minimum 2).
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  scan enable; low means the display is dark.
REQ-006 SHALL have port wr_valid  in  1  write request for a new display value.
REQ-007 SHALL have port wr_data  in  4*DIGITS  hex nibbles; nibble i is digit i, and digit 0 is the rightmost.
REQ-008 SHALL have port dp_in  in  DIGITS  decimal-point request per digit, sampled with wr_data.
REQ-009 SHALL have port wr_ready  out  1  write slot free (equals NOT pending_valid).
REQ-010 SHALL have port seg_n  out  7  active-low segments; bit0=a .. bit6=g.
REQ-011 SHALL have port dp_n  out  1  active-low decimal point.
REQ-012 SHALL have port an_n  out  DIGITS  active-low one-hot digit select.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse per completed scan frame.

Function
REQ-014 SHALL implement FSM states IDLE, BLANK and DRIVE, plus a prescaler counter, a digit index, a display register and a pending register with a pending_valid flag.
REQ-015 SHALL, in IDLE, hold an_n all ones, seg_n 7'h7F and dp_n 1, with the prescaler and index held at 0.
REQ-016 SHALL transition IDLE->BLANK when enable=1.
REQ-017 SHALL make BLANK last exactly 1 cycle (all anodes off, index already updated), then transition to DRIVE.
REQ-018 SHALL, in DRIVE, assert an_n[index]=0, drive seg_n with the decoded nibble index of the display register, and drive dp_n with NOT dp[index].
REQ-019 SHALL have the prescaler count 0..PRESCALE-1 in DRIVE; at PRESCALE-1 go to BLANK, clear the prescaler, and set index=(index+1) mod DIGITS.
REQ-020 SHALL make the frame period DIGITS*(PRESCALE+1) cycles.
REQ-021 SHALL define the frame boundary as the DRIVE terminal count with index=DIGITS-1.
REQ-022 SHALL, at the frame boundary, pulse frame_done during the following BLANK cycle and copy pending into the display register if pending_valid=1, clearing pending_valid.
REQ-023 SHALL accept a write on wr_valid AND wr_ready, capturing wr_data/dp_in into pending and setting pending_valid.
REQ-024 SHALL, when pending_valid=1, hold wr_ready=0 until the cycle after the transfer.
REQ-025 SHALL, when a write and a transfer coincide, perform the transfer first; the accepted write (only possible if pending was empty) stays pending until the next boundary.
REQ-026 SHALL, in IDLE, transfer pending to display on the cycle after acceptance.
REQ-027 SHALL, on enable=0 in any state, go to IDLE on the next edge, clearing prescaler and index; pending and display contents are kept.
REQ-028 SHALL drive outputs from registered state only, with no combinational path from inputs to outputs except wr_ready, which derives from a register.
REQ-029 SHALL decode with segment encodings 0=7'h40, 1=7'h79, 4=7'h19, 7=7'h78, 8=7'h00, F=7'h0E, with full standard hex 0-F.

Reset
REQ-030 SHALL, on reset assertion and immediately (asynchronously), put the FSM in IDLE, with prescaler=0, index=0, display=0, dp=0, pending_valid=0, an_n all ones, seg_n=7'h7F, dp_n=1, frame_done=0 and wr_ready=1.

Configuration
REQ-031 SHALL, when LEADING_ZERO_BLANK_EN is defined, blank (seg_n=7'h7F) any digit i>0 whose nibble and all higher nibbles are 0, while dp_n still follows dp.
REQ-032 SHALL, when LEADING_ZERO_BLANK_EN is undefined, decode every digit; the blanking logic is absent.

Structure
REQ-033 SHALL place the segment-code constants (SEG_BLANK, 16-entry hex table) and the state enum in package hex_scan_pkg.
REQ-034 SHALL instantiate combinational sub-module hex_seg_decoder (4-bit in, 7-bit active-low out) once, shared across all digits.

Verification (DIGITS=4, PRESCALE=4)
REQ-035 SHALL verify: reset asserted mid-DRIVE -> same cycle an_n=4'hF, seg_n=7'h7F, dp_n=1, wr_ready=1, frame_done=0.
REQ-036 SHALL verify: enable=1, no write -> frame_done every 20 cycles; each digit shows 7'h40 for 4 cycles, then 1 blank cycle.
REQ-037 SHALL verify: write 16'h1234 in DRIVE -> digits keep showing 0 until the boundary; then digit0 gives seg_n=7'h19 with an_n=4'b1110.
REQ-038 SHALL verify: two back-to-back writes -> wr_ready=0 after the first until the cycle after the boundary; the second value is not lost (held wr_valid).
REQ-039 SHALL verify: enable dropped mid-frame -> IDLE next cycle with a dark display; re-enable -> 1 BLANK cycle, then digit 0.
REQ-040 SHALL verify: 16'h0070 with LEADING_ZERO_BLANK_EN defined -> digits 3,2 blank, digit1=7'h78, digit0=7'h40; with it undefined -> digit3=7'h40.
